cacheline_mem_responder: RTL
============================

Name: cacheline_mem_responder

Overview:
- Memory-side responder for the cache's downstream (DFP) line interface; it answers the cache's readmem/write requests with full 256-bit lines.
- Holds a small line-addressed backing store and returns each response after a fixed, programmable latency.
- Used as the cache's DFP partner in unit benches and as a stand-in main memory in small integration tops.
- Also reports protocol violations and traffic counts for verification.

Parameters:
- LATENCY, 4: cycles from request accept to response; legal range 1..15.
- INDEX_BITS, 4: log2 of the number of lines held; address bits [5+INDEX_BITS-1:5] select the line.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- dfp_addr  in  32  line address from cache; bits [4:0] expected zero
- dfp_read  in  1  read request, held until dfp_resp
- dfp_write  in  1  write request, held until dfp_resp
- dfp_wdata  in  256  write line data
- dfp_rdata  out  256  read line data, valid only while dfp_resp=1
- dfp_resp  out  1  one-cycle response pulse
- proto_err  out  1  sticky violation flag
- rd_count  out  16  completed reads, saturating
- wr_count  out  16  completed writes, saturating

Behaviour:
- Reset (asynchronous, active-high): dfp_resp=0, dfp_rdata=0, proto_err=0, rd_count=0, wr_count=0, FSM=m_idle, latency counter=0, every storage line=0.
- Reset mid-transaction aborts the transaction: no response is produced and the storage is cleared.
- FSM m_idle:
  - If dfp_read|dfp_write at a rising edge, capture addr, op and wdata, load counter with LATENCY-1, and go to m_busy.
  - If LATENCY=1, go directly to m_resp instead.
- FSM m_busy: decrement the counter each cycle; at 0, go to m_resp.
- FSM m_resp:
  - Drive dfp_resp=1 for exactly one cycle, then return to m_idle.
  - Read: dfp_rdata = captured line.
  - Write: the storage line updates at the edge leaving m_resp, and dfp_rdata=0.
- Timing: a request first seen high in cycle 0 gets dfp_resp high in cycle LATENCY.
- Back-to-back: the cache deasserts the request on the edge where it samples resp, so m_idle may accept a new request in the cycle after m_resp. There is no dead cycle beyond this.
- Captured values are authoritative. Changes to addr, wdata or op after accept are ignored, and any change sets proto_err.
- dfp_read and dfp_write both high at accept: the write is performed and proto_err is set.
- dfp_addr[4:0] non-zero at accept: the offset is ignored (line-aligned access) and proto_err is set.
- Address bits above the index are ignored, so lines alias with period 2^(5+INDEX_BITS) bytes.
- Requests that drop before dfp_resp set proto_err; the transaction still completes.
- rd_count/wr_count increment in the m_resp cycle and saturate at 16'hFFFF.
- proto_err clears only on rst.

Decomposition:
- cache_types package gains:
  - enum mem_state_t {m_idle=2'b00, m_busy=2'b01, m_resp=2'b10}, matching the width of process_state_t.
  - localparams LINE_WIDTH=256, OFFSET_BITS=5.
- One sub-module, cacheline_store:
  - 2^INDEX_BITS x 256 register array.
  - Asynchronous clear, synchronous write enable, combinational read by index.
- The top level holds the FSM, counter, capture registers, checker and statistics counters.

Test Plan:
- Reset, then read addr 0x0000_0040 with LATENCY=4, request first high in cycle 0 -> dfp_resp=1 only in cycle 4, dfp_rdata=0, rd_count=1.
- Write 0x0000_0060 with wdata={8{32'hDEADBEEF}}, then a back-to-back read of 0x0000_0060 -> read resp returns {8{32'hDEADBEEF}}; wr_count=1, rd_count=1; second accept in the cycle after the first resp.
- Alias check with INDEX_BITS=4: write 0x0000_0200 with data A, read 0x0000_0000 -> returns A; proto_err=0.
- Violation: assert read and write together at 0x0000_0080 with data B -> write performed, proto_err=1 and stays 1. Separately, addr 0x0000_0084 -> line 0x80 accessed, proto_err=1.
- Assert rst in cycle 2 of a LATENCY=4 read -> no dfp_resp ever for it; all outputs 0; a subsequent read of a previously written line returns 0.
- LATENCY=1 sweep plus 65 540 reads -> each resp arrives the cycle after request; rd_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/cache_types_pkg.sv
// cache_types: shared types and constants for the cache's downstream memory side.
//   mem_state_t  - responder FSM states (2-bit encoding)
//   LINE_WIDTH   - bits per cache line
//   OFFSET_BITS  - byte-offset bits inside a line
//   sat_inc16    - saturating 16-bit increment used by the traffic counters
package cache_types;

    localparam int LINE_WIDTH  = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        m_idle = 2'b00,
        m_busy = 2'b01,
        m_resp = 2'b10
    } mem_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cacheline_mem_responder_store.sv
// cacheline_store: line-addressed backing store for the memory responder.
//   clk, rst   - clock, asynchronous active-high clear of every line
//   we         - write enable (sampled on rising edge)
//   widx/wdata - line index and data for the write
//   ridx/rdata - combinational read port
module cacheline_store
    import cache_types::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] widx,
    input  logic [LINE_WIDTH-1:0] wdata,
    input  logic [INDEX_BITS-1:0] ridx,
    output logic [LINE_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [LINE_WIDTH-1:0] lines_r [DEPTH];

    // Line array: cleared on reset, one line written per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lines_r[i] <= '0;
            end
        end else if (we) begin
            lines_r[widx] <= wdata;
        end
    end

    assign rdata = lines_r[ridx];

endmodule

// File: rtl/cacheline_mem_responder.sv
// cacheline_mem_responder: fixed-latency memory partner for the cache DFP port.
//   clk, rst          - clock, asynchronous active-high reset
//   dfp_addr          - line address (bits [4:0] should be zero)
//   dfp_read/write    - request strobes, held until dfp_resp
//   dfp_wdata         - write line data
//   dfp_rdata         - read data, non-zero only with dfp_resp on a read
//   dfp_resp          - one-cycle response pulse, LATENCY cycles after accept
//   proto_err         - sticky protocol-violation flag
//   rd_count/wr_count - saturating completed-transaction counters
module cacheline_mem_responder
    import cache_types::*;
#(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic                  proto_err,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

    mem_state_t            state_r;
    mem_state_t            state_next_s;
    logic [3:0]            cnt_r;
    logic [3:0]            cnt_next_s;
    logic [31:0]           cap_addr_r;
    logic                  cap_read_r;
    logic                  cap_write_r;
    logic [LINE_WIDTH-1:0] cap_wdata_r;
    logic                  resp_r;
    logic [LINE_WIDTH-1:0] rdata_r;
    logic                  err_r;
    logic [15:0]           rd_cnt_r;
    logic [15:0]           wr_cnt_r;

    logic                  accept_s;
    logic                  going_read_s;
    logic                  hold_bad_s;
    logic                  accept_bad_s;
    logic [INDEX_BITS-1:0] rd_idx_s;
    logic [INDEX_BITS-1:0] cap_idx_s;
    logic [LINE_WIDTH-1:0] rd_line_s;
    logic                  store_we_s;

    assign accept_s  = (state_r == m_idle) && (dfp_read || dfp_write);
    assign cap_idx_s = cap_addr_r[OFFSET_BITS +: INDEX_BITS];

    // Next-state and latency counter. The counter is loaded with LATENCY-1
    // and the FSM enters m_resp on the edge where it reaches zero, so the
    // pulse lands exactly LATENCY cycles after the request was first seen.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            m_idle: begin
                if (accept_s) begin
                    cnt_next_s = LOAD_VAL;
                    if (LATENCY == 1) begin
                        state_next_s = m_resp;
                    end else begin
                        state_next_s = m_busy;
                    end
                end else begin
                    state_next_s = m_idle;
                end
            end
            m_busy: begin
                if (cnt_r <= 4'd1) begin
                    cnt_next_s   = 4'd0;
                    state_next_s = m_resp;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                    state_next_s = m_busy;
                end
            end
            m_resp: begin
                cnt_next_s   = 4'd0;
                state_next_s = m_idle;
            end
            default: begin
                cnt_next_s   = 4'd0;
                state_next_s = m_idle;
            end
        endcase
    end

    // Read-data pre-fetch: when the next state is m_resp the line is looked
    // up one cycle early so dfp_rdata can be registered. With LATENCY=1 the
    // capture registers are not loaded yet, so the live request is used.
    always_comb begin
        rd_idx_s     = cap_idx_s;
        going_read_s = 1'b0;
        if (state_r == m_idle) begin
            rd_idx_s     = dfp_addr[OFFSET_BITS +: INDEX_BITS];
            going_read_s = (state_next_s == m_resp) && !dfp_write;
        end else begin
            rd_idx_s     = cap_idx_s;
            going_read_s = (state_next_s == m_resp) && !cap_write_r;
        end
    end

    // Protocol checks: anything moving after accept, or a bad request at accept.
    always_comb begin
        hold_bad_s   = 1'b0;
        accept_bad_s = 1'b0;
        if (state_r != m_idle) begin
            hold_bad_s = (dfp_addr  != cap_addr_r)  || (dfp_wdata != cap_wdata_r) ||
                         (dfp_read  != cap_read_r)  || (dfp_write != cap_write_r);
        end else begin
            hold_bad_s = 1'b0;
        end
        if (accept_s) begin
            accept_bad_s = (dfp_read && dfp_write) ||
                           (dfp_addr[OFFSET_BITS-1:0] != {OFFSET_BITS{1'b0}});
        end else begin
            accept_bad_s = 1'b0;
        end
    end

    assign store_we_s = (state_r == m_resp) && cap_write_r;

    cacheline_store #(
        .INDEX_BITS(INDEX_BITS)
    ) u_store (
        .clk  (clk),
        .rst  (rst),
        .we   (store_we_s),
        .widx (cap_idx_s),
        .wdata(cap_wdata_r),
        .ridx (rd_idx_s),
        .rdata(rd_line_s)
    );

    // FSM state and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= m_idle;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Request capture; the captured copy is what the transaction uses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr_r  <= 32'd0;
            cap_read_r  <= 1'b0;
            cap_write_r <= 1'b0;
            cap_wdata_r <= '0;
        end else if (accept_s) begin
            cap_addr_r  <= dfp_addr;
            cap_read_r  <= dfp_read;
            cap_write_r <= dfp_write;
            cap_wdata_r <= dfp_wdata;
        end
    end

    // Registered response pulse and read data (zero outside a read response).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_r  <= 1'b0;
            rdata_r <= '0;
        end else begin
            resp_r  <= (state_next_s == m_resp);
            rdata_r <= going_read_s ? rd_line_s : '0;
        end
    end

    // Sticky violation flag and saturating traffic counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r    <= 1'b0;
            rd_cnt_r <= 16'd0;
            wr_cnt_r <= 16'd0;
        end else begin
            err_r <= err_r | hold_bad_s | accept_bad_s;
            if (state_r == m_resp) begin
                if (cap_write_r) begin
                    wr_cnt_r <= sat_inc16(wr_cnt_r);
                end else begin
                    rd_cnt_r <= sat_inc16(rd_cnt_r);
                end
            end
        end
    end

    assign dfp_resp  = resp_r;
    assign dfp_rdata = rdata_r;
    assign proto_err = err_r;
    assign rd_count  = rd_cnt_r;
    assign wr_count  = wr_cnt_r;

endmodule
